// File: rtl/read_sdram_fifo_burst_if.sv
// ---------------------------------------------------------------------------
// read_sdram_fifo_burst_if
// Bundles every non-clock signal of read_sdram_fifo_burst.
//   User request side : rd_start, rd_addr[31:0], rd_burst_num[15:0] in;
//                       dev_idle, rd_done out.
//   User FIFO side    : user_rd_en in; user_data[15:0], user_data_valid,
//                       user_empty out.
//   Memory master side: master_address[31:0], master_read,
//                       master_burstcount[7:0], master_byteenable[1:0] out;
//                       master_waitrequest, master_readdata[15:0],
//                       master_readdatavalid in.
// Modport "master" is the reader block's view; "slave" is the view of
// whatever surrounds it (user logic plus the memory slave).
// ---------------------------------------------------------------------------
interface read_sdram_fifo_burst_if;
    logic        rd_start;
    logic [31:0] rd_addr;
    logic [15:0] rd_burst_num;
    logic        dev_idle;
    logic        rd_done;

    logic        user_rd_en;
    logic [15:0] user_data;
    logic        user_data_valid;
    logic        user_empty;

    logic [31:0] master_address;
    logic        master_read;
    logic [7:0]  master_burstcount;
    logic [1:0]  master_byteenable;
    logic        master_waitrequest;
    logic [15:0] master_readdata;
    logic        master_readdatavalid;

    modport master (
        input  rd_start, rd_addr, rd_burst_num, user_rd_en,
               master_waitrequest, master_readdata, master_readdatavalid,
        output dev_idle, rd_done, user_data, user_data_valid, user_empty,
               master_address, master_read, master_burstcount, master_byteenable
    );

    modport slave (
        output rd_start, rd_addr, rd_burst_num, user_rd_en,
               master_waitrequest, master_readdata, master_readdatavalid,
        input  dev_idle, rd_done, user_data, user_data_valid, user_empty,
               master_address, master_read, master_burstcount, master_byteenable
    );
endinterface

// File: rtl/read_sdram_fifo_burst.sv
// ---------------------------------------------------------------------------
// read_sdram_fifo_burst
// Reads rd_burst_num bursts of 16 x 16-bit beats from a memory slave starting
// at a 32-byte aligned address and buffers them in a 32-word FIFO that the
// user drains with user_rd_en (one-cycle pop latency).
// Ports:
//   clk     : sole clock, rising edge.
//   reset_n : asynchronous active-low reset; aborts any transfer in flight.
//   bus     : read_sdram_fifo_burst_if.master (request, FIFO and memory
//             master signals, see the interface file).
// A burst is only requested while credit (FIFO fill + beats still owed by
// the slave) is at most 16, so a returning burst always fits in the FIFO.
// Build option: define READ_SDRAM_PIPELINE_EN to allow a second burst
// command to be issued back-to-back while the first is still outstanding.
// ---------------------------------------------------------------------------
module read_sdram_fifo_burst (
    input  logic                          clk,
    input  logic                          reset_n,
    read_sdram_fifo_burst_if.master       bus
);

`ifdef READ_SDRAM_PIPELINE_EN
    localparam bit PIPELINE = 1'b1;
`else
    localparam bit PIPELINE = 1'b0;
`endif

    localparam int         DATA_W      = 16;
    localparam logic [5:0] BURST_BEATS = 6'd16;
    localparam logic [5:0] ISSUE_LIMIT = 6'd16;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;

    state_t              r_state;
    logic [31:0]         r_addr;
    logic                r_read;
    logic [15:0]         r_remaining;
    logic [5:0]          r_outstanding;
    logic [5:0]          r_fill;
    logic [4:0]          r_wr_ptr;
    logic [4:0]          r_rd_ptr;
    logic [DATA_W-1:0]   r_mem [32];
    logic [DATA_W-1:0]   r_user_data;
    logic                r_user_valid;
    logic                r_rd_done;
    logic                r_dev_idle;

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [5:0]          w_credit;
    logic [5:0]          w_out_next;
    logic [5:0]          w_fill_next;
    logic [5:0]          w_credit_next;
    logic [15:0]         w_rem_next;

    assign w_accept      = r_read & ~bus.master_waitrequest;
    // Beats are only accepted while a transfer is active and owes data; this
    // drops stray beats that arrive after a reset aborted a transfer.
    assign w_push        = bus.master_readdatavalid
                         & ((r_state == REQ) || (r_state == WAIT_DATA))
                         & (r_outstanding != 6'd0);
    assign w_pop         = bus.user_rd_en & (r_fill != 6'd0);
    assign w_credit      = r_fill + r_outstanding;
    assign w_out_next    = r_outstanding + (w_accept ? BURST_BEATS : 6'd0) - {5'd0, w_push};
    assign w_fill_next   = r_fill + {5'd0, w_push} - {5'd0, w_pop};
    assign w_credit_next = w_fill_next + w_out_next;
    assign w_rem_next    = r_remaining - {15'd0, w_accept};

    assign bus.master_address    = r_addr;
    assign bus.master_read       = r_read;
    assign bus.master_burstcount = 8'd16;
    assign bus.master_byteenable = 2'b11;
    assign bus.user_data         = r_user_data;
    assign bus.user_data_valid   = r_user_valid;
    assign bus.user_empty        = (r_fill == 6'd0);
    assign bus.rd_done           = r_rd_done;
    assign bus.dev_idle          = r_dev_idle;

    // FIFO storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.master_readdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_addr        <= 32'd0;
            r_read        <= 1'b0;
            r_remaining   <= 16'd0;
            r_outstanding <= 6'd0;
            r_fill        <= 6'd0;
            r_wr_ptr      <= 5'd0;
            r_rd_ptr      <= 5'd0;
            r_user_data   <= '0;
            r_user_valid  <= 1'b0;
            r_rd_done     <= 1'b0;
            r_dev_idle    <= 1'b1;
        end else begin
            r_outstanding <= w_out_next;
            r_fill        <= w_fill_next;
            r_user_valid  <= w_pop;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 5'd1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 5'd1;
                r_user_data <= r_mem[r_rd_ptr];
            end

            case (r_state)
                IDLE: begin
                    if (bus.rd_start) begin
                        r_dev_idle <= 1'b0;
                        if (bus.rd_burst_num != 16'd0) begin
                            r_addr      <= bus.rd_addr;
                            r_remaining <= bus.rd_burst_num;
                            r_state     <= REQ;
                        end else begin
                            r_rd_done <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end

                REQ: begin
                    if (r_read) begin
                        // While waitrequest is high nothing here changes, so
                        // address and read stay stable until acceptance.
                        if (w_accept) begin
                            r_addr      <= r_addr + 32'd32;
                            r_remaining <= w_rem_next;
                            if (PIPELINE && (w_rem_next != 16'd0)
                                && (w_credit_next <= ISSUE_LIMIT)) begin
                                r_read <= 1'b1;
                            end else begin
                                r_read  <= 1'b0;
                                r_state <= WAIT_DATA;
                            end
                        end
                    end else if (w_credit <= ISSUE_LIMIT) begin
                        r_read <= 1'b1;
                    end
                end

                WAIT_DATA: begin
                    if (w_out_next == 6'd0) begin
                        if (r_remaining != 16'd0) begin
                            r_state <= REQ;
                        end else begin
                            r_rd_done <= 1'b1;
                            r_state   <= DONE;
                        end
                    end
                end

                DONE: begin
                    r_rd_done  <= 1'b0;
                    r_dev_idle <= 1'b1;
                    r_state    <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_sdram_fifo_burst.sv
`timescale 1ns/1ps
module tb_read_sdram_fifo_burst;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    read_sdram_fifo_burst_if bus();

    read_sdram_fifo_burst dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory slave model: each accepted command returns 16 beats whose data
    // is the half-word index (address >> 1) of each beat.
    typedef struct {
        logic [31:0] addr;
        int unsigned ready;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] cmd_addr[$];
    int unsigned cmd_cyc[$];
    int unsigned beat_cyc[$];
    int unsigned done_cyc[$];
    logic [15:0] got[$];
    int          beats_left = 0;
    logic [15:0] cur_word   = 16'd0;
    logic        wait_force = 1'b0;
    int unsigned lat        = 3;

    initial begin
        bus.master_waitrequest   = 1'b0;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata      = 16'd0;
        forever begin
            @(negedge clk);
            if (bus.user_data_valid) got.push_back(bus.user_data);
            if (bus.rd_done) done_cyc.push_back(cyc);
            bus.master_readdatavalid = 1'b0;
            if (beats_left == 0 && pend.size() > 0 && pend[0].ready <= cyc) begin
                cur_word   = pend[0].addr[16:1];
                beats_left = 16;
                void'(pend.pop_front());
            end
            if (beats_left > 0) begin
                bus.master_readdatavalid = 1'b1;
                bus.master_readdata      = cur_word;
                cur_word                 = cur_word + 16'd1;
                beats_left               = beats_left - 1;
                beat_cyc.push_back(cyc + 1);
            end
            bus.master_waitrequest = wait_force;
            if (bus.master_read && !wait_force && reset_n) begin
                cmd_addr.push_back(bus.master_address);
                cmd_cyc.push_back(cyc + 1);
                pend.push_back('{bus.master_address, cyc + 1 + lat});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [15:0] n);
        bus.rd_addr      = a;
        bus.rd_burst_num = n;
        bus.rd_start     = 1'b1;
        step();
        bus.rd_start     = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int k = 0;
        while (done_cyc.size() <= base && k < budget) begin
            step();
            k++;
        end
        if (done_cyc.size() <= base) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: rd_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int k = 0;
        while (got.size() < n && k < budget) begin
            step();
            k++;
        end
        if (got.size() < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: only %0d of %0d words popped", name, got.size(), n);
        end
    endtask

    task automatic check_words(input string name, input logic [15:0] first, input int n);
        int bad = 0;
        logic [15:0] e;
        for (int j = 0; j < n; j++) begin
            e = first + 16'(j);
            if (j >= got.size()) bad++;
            else if (got[j] !== e) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [15:0] num;
        int          exp_cmds;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int cb, bb, db, gb, k, nw;
        logic [31:0] a_first, a_last;

        vecs[0] = '{32'h0000_0100, 16'd1, 1, 32'h0000_0100};
        vecs[1] = '{32'h0000_1000, 16'd3, 3, 32'h0000_1040};
        vecs[2] = '{32'hFFFF_FFC0, 16'd3, 3, 32'h0000_0000};
        vecs[3] = '{32'h0000_0020, 16'd2, 2, 32'h0000_0040};

        reset_n          = 1'b0;
        bus.rd_start     = 1'b0;
        bus.rd_addr      = 32'd0;
        bus.rd_burst_num = 16'd0;
        bus.user_rd_en   = 1'b0;
        step();
        step();
        check("rst_read",       32'(bus.master_read),       32'd0);
        check("rst_addr",       bus.master_address,         32'd0);
        check("rst_done",       32'(bus.rd_done),           32'd0);
        check("rst_valid",      32'(bus.user_data_valid),   32'd0);
        check("rst_data",       32'(bus.user_data),         32'd0);
        check("rst_empty",      32'(bus.user_empty),        32'd1);
        check("rst_idle",       32'(bus.dev_idle),          32'd1);
        check("burstcount",     32'(bus.master_burstcount), 32'd16);
        check("byteenable",     32'(bus.master_byteenable), 32'd3);
        reset_n = 1'b1;
        step();

        // Table of complete transfers with continuous popping.
        for (int i = 0; i < 4; i++) begin
            got.delete();
            bus.user_rd_en = 1'b1;
            cb = cmd_addr.size();
            bb = beat_cyc.size();
            db = done_cyc.size();
            nw = 16 * int'(vecs[i].num);
            start(vecs[i].addr, vecs[i].num);
            wait_done(db, 400, $sformatf("v%0d_done", i));
            wait_words(nw, 100, $sformatf("v%0d_words", i));
            step();
            a_first = (cmd_addr.size() > cb) ? cmd_addr[cb] : 32'hDEAD_BEEF;
            a_last  = (cmd_addr.size() > cb) ? cmd_addr[cmd_addr.size()-1] : 32'hDEAD_BEEF;
            check($sformatf("v%0d_ncmd", i),  32'(cmd_addr.size() - cb), 32'(vecs[i].exp_cmds));
            check($sformatf("v%0d_first", i), a_first, vecs[i].addr);
            check($sformatf("v%0d_last", i),  a_last,  vecs[i].exp_last);
            check_words($sformatf("v%0d_data", i), vecs[i].addr[16:1], nw);
            check($sformatf("v%0d_donecyc", i),
                  (done_cyc.size() > db) ? done_cyc[db] : 32'hFFFF_FFFF,
                  (beat_cyc.size() >= bb + nw) ? beat_cyc[bb + nw - 1] : 32'hFFFF_FFFE);
            check($sformatf("v%0d_ndone", i), 32'(done_cyc.size() - db), 32'd1);
            check($sformatf("v%0d_idle", i),  32'(bus.dev_idle), 32'd1);
        end

        // Backpressure: command held stable for 5 waitrequest cycles.
        got.delete();
        cb = cmd_addr.size();
        db = done_cyc.size();
        wait_force = 1'b1;
        start(32'h0000_7000, 16'd1);
        k = 0;
        while (!bus.master_read && k < 10) begin step(); k++; end
        check("bp_read_rise", 32'(bus.master_read), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_read_hold", 32'(bus.master_read), 32'd1);
            check("bp_addr_hold", bus.master_address, 32'h0000_7000);
        end
        wait_force = 1'b0;
        wait_done(db, 200, "bp_done");
        wait_words(16, 50, "bp_words");
        check("bp_ncmd", 32'(cmd_addr.size() - cb), 32'd1);
        check("bp_addr", (cmd_addr.size() > cb) ? cmd_addr[cb] : 32'hDEAD_BEEF, 32'h0000_7000);
        check_words("bp_data", 16'h3800, 16);

        // Full FIFO: two bursts then stall; popping 16 words releases a third.
        got.delete();
        bus.user_rd_en = 1'b0;
        cb = cmd_addr.size();
        bb = beat_cyc.size();
        db = done_cyc.size();
        start(32'h0000_2000, 16'd4);
        k = 0;
        while (beat_cyc.size() < bb + 32 && k < 200) begin step(); k++; end
        repeat (20) step();
        check("full_ncmd2",  32'(cmd_addr.size() - cb), 32'd2);
        check("full_noread", 32'(bus.master_read),      32'd0);
        check("full_nempty", 32'(bus.user_empty),       32'd0);
        bus.user_rd_en = 1'b1;
        step();
        bus.user_rd_en = 1'b0;
        check("pop_valid",   32'(bus.user_data_valid), 32'd1);
        check("pop_data",    32'(bus.user_data),       32'h1000);
        step();
        check("pop_novalid", 32'(bus.user_data_valid), 32'd0);
        check("pop_hold",    32'(bus.user_data),       32'h1000);
        check("full_still2", 32'(cmd_addr.size() - cb), 32'd2);
        bus.user_rd_en = 1'b1;
        repeat (15) step();
        bus.user_rd_en = 1'b0;
        k = 0;
        while (cmd_addr.size() < cb + 3 && k < 30) begin step(); k++; end
        check("full_ncmd3", 32'(cmd_addr.size() - cb), 32'd3);
        check("full_addr3", (cmd_addr.size() > cb + 2) ? cmd_addr[cb+2] : 32'hDEAD_BEEF, 32'h0000_2040);
        bus.user_rd_en = 1'b1;
        wait_done(db, 400, "full_done");
        wait_words(64, 100, "full_words");
        check_words("full_data", 16'h1000, 64);

        // Command pipelining versus single outstanding burst.
        got.delete();
        cb = cmd_addr.size();
        bb = beat_cyc.size();
        db = done_cyc.size();
        start(32'h0000_4000, 16'd2);
        wait_done(db, 300, "pipe_done");
        wait_words(32, 50, "pipe_words");
`ifdef READ_SDRAM_PIPELINE_EN
        check("pipe_2nd_before_beat1",
              32'((cmd_cyc.size() > cb + 1 && beat_cyc.size() > bb) && (cmd_cyc[cb+1] < beat_cyc[bb])), 32'd1);
`else
        check("pipe_2nd_after_beat16",
              32'((cmd_cyc.size() > cb + 1 && beat_cyc.size() > bb + 15) && (cmd_cyc[cb+1] > beat_cyc[bb+15])), 32'd1);
`endif
        check_words("pipe_data", 16'h2000, 32);

        // Zero-length request.
        cb = cmd_addr.size();
        start(32'h0000_9000, 16'd0);
        check("zero_done",   32'(bus.rd_done),  32'd1);
        check("zero_busy",   32'(bus.dev_idle), 32'd0);
        step();
        check("zero_doneoff", 32'(bus.rd_done),  32'd0);
        check("zero_idle",    32'(bus.dev_idle), 32'd1);
        check("zero_ncmd",    32'(cmd_addr.size() - cb), 32'd0);

        // rd_start while busy is ignored.
        got.delete();
        cb = cmd_addr.size();
        db = done_cyc.size();
        start(32'h0000_5000, 16'd1);
        step();
        start(32'h0000_6000, 16'd5);
        wait_done(db, 200, "ign_done");
        wait_words(16, 50, "ign_words");
        repeat (20) step();
        check("ign_ncmd",  32'(cmd_addr.size() - cb), 32'd1);
        check("ign_addr",  (cmd_addr.size() > cb) ? cmd_addr[cb] : 32'hDEAD_BEEF, 32'h0000_5000);
        check("ign_ndone", 32'(done_cyc.size() - db), 32'd1);
        check_words("ign_data", 16'h2800, 16);

        // Reset in the middle of a burst; stray beats must not be stored.
        bus.user_rd_en = 1'b0;
        bb = beat_cyc.size();
        start(32'h0000_3000, 16'd2);
        k = 0;
        while (beat_cyc.size() < bb + 5 && k < 100) begin step(); k++; end
        reset_n = 1'b0;
        #1;
        check("mid_rst_read",  32'(bus.master_read),     32'd0);
        check("mid_rst_addr",  bus.master_address,       32'd0);
        check("mid_rst_done",  32'(bus.rd_done),         32'd0);
        check("mid_rst_valid", 32'(bus.user_data_valid), 32'd0);
        check("mid_rst_data",  32'(bus.user_data),       32'd0);
        check("mid_rst_empty", 32'(bus.user_empty),      32'd1);
        check("mid_rst_idle",  32'(bus.dev_idle),        32'd1);
        step();
        reset_n = 1'b1;
        k = 0;
        while ((pend.size() > 0 || beats_left > 0) && k < 100) begin step(); k++; end
        repeat (3) step();
        check("stray_empty", 32'(bus.user_empty), 32'd1);
        check("stray_idle",  32'(bus.dev_idle),   32'd1);
        gb = got.size();
        bus.user_rd_en = 1'b1;
        repeat (3) step();
        check("stray_nopop", 32'(got.size() - gb), 32'd0);

        // Recovery after reset.
        got.delete();
        db = done_cyc.size();
        start(32'h0000_8000, 16'd1);
        wait_done(db, 200, "rec_done");
        wait_words(16, 50, "rec_words");
        check_words("rec_data", 16'h4000, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
